// File: rtl/hpdcache_pkg.sv
// hpdcache_pkg: CMO operation encoding and CMO range FSM state type
package hpdcache_pkg;
  typedef struct packed {
    logic fence;
    logic inval_nline;
    logic inval_set;
    logic inval_all;
    logic inval_range;
  } hpdcache_cmo_op_t;
  typedef enum logic [2:0] {
    CMO_IDLE,
    CMO_FENCE_WAIT,
    CMO_DRAIN_WAIT,
    CMO_CHECK,
    CMO_INVAL
  } hpdcache_cmo_state_t;
endpackage

// File: rtl/hpdcache_cmo_range.sv
// hpdcache_cmo_range: fence and directory invalidation sequencer (line, range, set, whole cache)
module hpdcache_cmo_range
  import hpdcache_pkg::*;
#(
  parameter int unsigned SETS     = 128,
  parameter int unsigned WAYS     = 8,
  parameter int unsigned PA_W     = 49,
  parameter int unsigned OFFSET_W = 6,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned SET_W   = $clog2(SETS),
  localparam int unsigned TAG_W   = PA_W - OFFSET_W - SET_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wbuf_empty_i,
  input  logic              mshr_empty_i,
  input  logic              rtab_empty_i,
  input  logic              ctrl_empty_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        req_op_i,
  input  logic [PA_W-1:0]   req_addr_i,
  input  logic [31:0]       req_arg_i,
  output logic              wbuf_flush_all_o,
  output logic              done_o,
  output logic              dir_check_o,
  output logic [SET_W-1:0]  dir_check_set_o,
  output logic [TAG_W-1:0]  dir_check_tag_o,
  input  logic [WAYS-1:0]   dir_check_hit_way_i,
  output logic              dir_inval_o,
  output logic [SET_W-1:0]  dir_inval_set_o,
  output logic [WAYS-1:0]   dir_inval_way_o,
  input  logic              dir_busy_i
);
  localparam int unsigned NLINE_W = PA_W - OFFSET_W;
  hpdcache_cmo_state_t state_q, acc_nxt;
  hpdcache_cmo_op_t    op, op_q;
  logic [NLINE_W-1:0]  nline_q;
  logic [WAYS-1:0]     mask_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [SET_W-1:0]    set_cnt_q;
  logic accept, drained, fence_ok, lin_q, inval_go, done;
  logic unused_bits;
  assign op       = hpdcache_cmo_op_t'(req_op_i);
  assign accept   = state_q == CMO_IDLE && req_valid_i && $onehot(req_op_i);
  assign drained  = mshr_empty_i & rtab_empty_i & ctrl_empty_i;
  assign fence_ok = wbuf_empty_i & rtab_empty_i;
  assign lin_q    = op_q.inval_nline | op_q.inval_range;
  // line-based ops must consume the hit vector the cycle after the check, so busy only stalls set/all
  assign inval_go = state_q == CMO_INVAL && (lin_q || !dir_busy_i);
  assign done = (fence_ok && ((accept && op.fence) || state_q == CMO_FENCE_WAIT)) ||
                (inval_go && (op_q.inval_nline || op_q.inval_set ||
                              (op_q.inval_range && cnt_q <= CNT_W'(1)) ||
                              (op_q.inval_all && set_cnt_q == SET_W'(SETS - 1))));
  assign acc_nxt = op.fence ? (fence_ok ? CMO_IDLE : CMO_FENCE_WAIT) :
                   !drained ? CMO_DRAIN_WAIT :
                   (op.inval_nline | op.inval_range) ? CMO_CHECK : CMO_INVAL;
  assign req_ready_o      = state_q == CMO_IDLE;
  assign wbuf_flush_all_o = rtab_empty_i && ((accept && op.fence) || state_q == CMO_FENCE_WAIT);
  assign done_o           = done;
  assign dir_check_o      = state_q == CMO_CHECK && !dir_busy_i;
  assign dir_check_set_o  = dir_check_o ? nline_q[SET_W-1:0] : '0;
  assign dir_check_tag_o  = dir_check_o ? nline_q[NLINE_W-1:SET_W] : '0;
  assign dir_inval_o      = inval_go && (!lin_q || |dir_check_hit_way_i);
  assign dir_inval_set_o  = !dir_inval_o ? '0 : op_q.inval_all ? set_cnt_q : nline_q[SET_W-1:0];
  assign dir_inval_way_o  = !dir_inval_o ? '0 : lin_q ? dir_check_hit_way_i :
                            op_q.inval_set ? mask_q : '1;
  assign unused_bits      = ^{req_addr_i[OFFSET_W-1:0], req_arg_i, op_q.fence};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= CMO_IDLE;
    else begin
      case (state_q)
        CMO_IDLE:       if (accept) state_q <= acc_nxt;
        CMO_FENCE_WAIT: if (fence_ok) state_q <= CMO_IDLE;
        CMO_DRAIN_WAIT: if (drained) state_q <= lin_q ? CMO_CHECK : CMO_INVAL;
        CMO_CHECK:      if (!dir_busy_i) state_q <= CMO_INVAL;
        CMO_INVAL:      state_q <= done ? CMO_IDLE : (inval_go && op_q.inval_range) ? CMO_CHECK : CMO_INVAL;
        default:        state_q <= CMO_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q      <= op;
      nline_q   <= req_addr_i[PA_W-1:OFFSET_W];
      mask_q    <= req_arg_i[WAYS-1:0];
      cnt_q     <= req_arg_i[CNT_W-1:0];
      set_cnt_q <= '0;
    end else if (inval_go && op_q.inval_range) begin
      nline_q <= nline_q + NLINE_W'(1);
      cnt_q   <= cnt_q - CNT_W'(1);
    end else if (inval_go && op_q.inval_all) begin
      set_cnt_q <= set_cnt_q + SET_W'(1);
    end
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) req_valid_i |-> req_ready_o && $onehot(req_op_i));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(dir_check_o && dir_inval_o));
endmodule

// File: tb/tb_hpdcache_cmo_range.sv
// tb_hpdcache_cmo_range: vector table plus event scoreboard for the CMO sequencer
module tb_hpdcache_cmo_range;
  localparam int SETS = 128, WAYS = 8, PA_W = 49, OFFSET_W = 6, CNT_W = 16;
  localparam int SET_W = 7, TAG_W = 36, NLW = PA_W - OFFSET_W;
  localparam logic [4:0] OP_FENCE = 5'b10000, OP_NLINE = 5'b01000, OP_SET = 5'b00100,
                         OP_ALL = 5'b00010, OP_RANGE = 5'b00001;
  logic clk_i = 1'b0, rst_ni;
  logic wbuf_empty_i, mshr_empty_i, rtab_empty_i, ctrl_empty_i;
  logic req_valid_i, req_ready_o;
  logic [4:0] req_op_i;
  logic [PA_W-1:0] req_addr_i;
  logic [31:0] req_arg_i;
  logic wbuf_flush_all_o, done_o, dir_check_o, dir_inval_o, dir_busy_i;
  logic [SET_W-1:0] dir_check_set_o, dir_inval_set_o;
  logic [TAG_W-1:0] dir_check_tag_o;
  logic [WAYS-1:0] dir_check_hit_way_i, dir_inval_way_o;
  hpdcache_cmo_range #(.SETS(SETS), .WAYS(WAYS), .PA_W(PA_W), .OFFSET_W(OFFSET_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wbuf_empty_i(wbuf_empty_i), .mshr_empty_i(mshr_empty_i),
    .rtab_empty_i(rtab_empty_i), .ctrl_empty_i(ctrl_empty_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_arg_i(req_arg_i),
    .wbuf_flush_all_o(wbuf_flush_all_o), .done_o(done_o),
    .dir_check_o(dir_check_o), .dir_check_set_o(dir_check_set_o), .dir_check_tag_o(dir_check_tag_o),
    .dir_check_hit_way_i(dir_check_hit_way_i),
    .dir_inval_o(dir_inval_o), .dir_inval_set_o(dir_inval_set_o), .dir_inval_way_o(dir_inval_way_o),
    .dir_busy_i(dir_busy_i)
  );
  always #5 clk_i = ~clk_i;
  // kind: 0 = dir check (set, tag), 1 = dir inval (set, way), 2 = done
  typedef struct { int kind; longint unsigned set; longint unsigned data; } ev_t;
  ev_t sbq[$];
  int total = 0, bad = 0;
  typedef struct {
    logic [4:0] op; logic [PA_W-1:0] addr; logic [31:0] arg; logic [WAYS-1:0] hit;
    logic wbuf_e; logic exp_check; logic [SET_W-1:0] set; logic [TAG_W-1:0] tag;
    logic exp_inval; logic [WAYS-1:0] way; logic exp_flush;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic void push(input int k, input longint unsigned s, input longint unsigned d);
    ev_t e;
    e.kind = k; e.set = s; e.data = d;
    sbq.push_back(e);
  endfunction
  task automatic got(input int k, input longint unsigned s, input longint unsigned d);
    ev_t e;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_unexpected kind=%0d set=%0h data=%0h required=no_event", k, s, d);
    end else begin
      e = sbq.pop_front();
      chk("ev_kind", 64'(k), 64'(e.kind));
      chk("ev_set", s, e.set);
      chk("ev_data", d, e.data);
    end
  endtask
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (dir_check_o | dir_inval_o) chk("check_inval_excl", 64'(dir_check_o & dir_inval_o), 64'd0);
      if (dir_check_o) got(0, 64'(dir_check_set_o), 64'(dir_check_tag_o));
      if (dir_inval_o) got(1, 64'(dir_inval_set_o), 64'(dir_inval_way_o));
      if (done_o) got(2, 64'd0, 64'd0);
    end
  end
  task automatic send(input logic [4:0] op, input logic [PA_W-1:0] addr, input logic [31:0] arg, output logic fl);
    req_valid_i = 1'b1; req_op_i = op; req_addr_i = addr; req_arg_i = arg;
    @(negedge clk_i);
    chk("req_ready_idle", 64'(req_ready_o), 64'd1);
    fl = wbuf_flush_all_o;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask
  task automatic wait_idle(input int max);
    int n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < max) begin
      @(negedge clk_i);
      n++;
    end
    chk("idle_reached", 64'(req_ready_o), 64'd1);
    @(posedge clk_i);
    #1 chk("sb_drained", 64'(sbq.size()), 64'd0);
  endtask
  task automatic range_test(input logic [PA_W-1:0] addr, input int cnt, input logic [WAYS-1:0] hit);
    logic [NLW-1:0] line;
    int n;
    logic fl;
    line = addr[PA_W-1:OFFSET_W];
    n = (cnt == 0) ? 1 : cnt;
    for (int i = 0; i < n; i++) begin
      push(0, 64'(line[SET_W-1:0]), 64'(line[NLW-1:SET_W]));
      if (hit != '0) push(1, 64'(line[SET_W-1:0]), 64'(hit));
      line = line + NLW'(1);
    end
    push(2, 64'd0, 64'd0);
    dir_check_hit_way_i = hit;
    send(OP_RANGE, addr, 32'(cnt), fl);
    wait_idle(4 * n + 10);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    logic fl;
    tbl[0] = '{OP_NLINE, 49'h1240,   32'h0,         8'h10, 1'b1, 1'b1, 7'd73,   36'h0,   1'b1, 8'h10, 1'b0};
    tbl[1] = '{OP_NLINE, 49'hB4ACC0, 32'h0,         8'h81, 1'b1, 1'b1, 7'h33,   36'h5A5, 1'b1, 8'h81, 1'b0};
    tbl[2] = '{OP_NLINE, 49'h40,     32'h0,         8'h00, 1'b1, 1'b1, 7'd1,    36'h0,   1'b0, 8'h00, 1'b0};
    tbl[3] = '{OP_SET,   49'h240,    32'h5,         8'hFF, 1'b1, 1'b0, 7'd9,    36'h0,   1'b1, 8'h05, 1'b0};
    tbl[4] = '{OP_SET,   49'hFFC0,   32'hFF,        8'h00, 1'b1, 1'b0, 7'd127,  36'h0,   1'b1, 8'hFF, 1'b0};
    tbl[5] = '{OP_SET,   49'h140,    32'hFFFFFF03,  8'h00, 1'b1, 1'b0, 7'd5,    36'h0,   1'b1, 8'h03, 1'b0};
    tbl[6] = '{OP_FENCE, 49'h0,      32'h0,         8'h00, 1'b1, 1'b0, 7'd0,    36'h0,   1'b0, 8'h00, 1'b1};
    rst_ni = 1'b0;
    wbuf_empty_i = 1'b1; mshr_empty_i = 1'b1; rtab_empty_i = 1'b1; ctrl_empty_i = 1'b1;
    req_valid_i = 1'b0; req_op_i = '0; req_addr_i = '0; req_arg_i = '0;
    dir_check_hit_way_i = '0; dir_busy_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("reset_outputs", 64'({req_ready_o, done_o, wbuf_flush_all_o, dir_check_o, dir_inval_o}), 64'b10000);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].exp_check) push(0, 64'(tbl[i].set), 64'(tbl[i].tag));
      if (tbl[i].exp_inval) push(1, 64'(tbl[i].set), 64'(tbl[i].way));
      push(2, 64'd0, 64'd0);
      dir_check_hit_way_i = tbl[i].hit;
      wbuf_empty_i = tbl[i].wbuf_e;
      send(tbl[i].op, tbl[i].addr, tbl[i].arg, fl);
      if (tbl[i].op == OP_FENCE) chk("fence_flush", 64'(fl), 64'(tbl[i].exp_flush));
      wait_idle(20);
    end
    // fence held by a non-empty write buffer for five cycles
    wbuf_empty_i = 1'b0;
    send(OP_FENCE, '0, '0, fl);
    chk("fence_wait_flush_first", 64'(fl), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("fence_wait_flush", 64'(wbuf_flush_all_o), 64'd1);
      chk("fence_wait_ready", 64'(req_ready_o), 64'd0);
      @(posedge clk_i);
      #1;
    end
    wbuf_empty_i = 1'b1;
    push(2, 64'd0, 64'd0);
    wait_idle(5);
    range_test(49'h1FC0, 3, 8'h02);
    range_test({PA_W{1'b1}}, 2, 8'h40);
    range_test(49'h80, 0, 8'h01);
    range_test(49'h3000, 2, 8'h00);
    // check stalled by dir_busy_i
    push(0, 64'd2, 64'd0); push(1, 64'd2, 64'h04); push(2, 64'd0, 64'd0);
    dir_check_hit_way_i = 8'h04; dir_busy_i = 1'b1;
    send(OP_NLINE, 49'h80, '0, fl);
    repeat (2) @(posedge clk_i);
    #1 dir_busy_i = 1'b0;
    wait_idle(10);
    // whole-cache sweep with a two-cycle directory stall
    for (int s = 0; s < SETS; s++) push(1, 64'(s), 64'hFF);
    push(2, 64'd0, 64'd0);
    send(OP_ALL, '0, '0, fl);
    repeat (50) @(posedge clk_i);
    #1 dir_busy_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 dir_busy_i = 1'b0;
    wait_idle(300);
    // line invalidation waiting for the MSHR to drain, then a miss
    push(0, 64'd1, 64'd0); push(2, 64'd0, 64'd0);
    dir_check_hit_way_i = 8'h00; mshr_empty_i = 1'b0;
    send(OP_NLINE, 49'h40, '0, fl);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("drain_ready", 64'(req_ready_o), 64'd0);
      @(posedge clk_i);
      #1;
    end
    mshr_empty_i = 1'b1;
    wait_idle(10);
    // reset during a 10-line range after two lines
    push(0, 64'd0, 64'd0); push(1, 64'd0, 64'h01); push(0, 64'd1, 64'd0); push(1, 64'd1, 64'h01);
    dir_check_hit_way_i = 8'h01;
    send(OP_RANGE, '0, 32'd10, fl);
    repeat (4) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    @(negedge clk_i);
    chk("abort_outputs", 64'({req_ready_o, done_o, dir_check_o, dir_inval_o}), 64'b1000);
    chk("abort_sb", 64'(sbq.size()), 64'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("abort_idle", 64'({req_ready_o, done_o}), 64'b10);
    @(posedge clk_i);
    #1;
    push(0, 64'd73, 64'd0); push(1, 64'd73, 64'h20); push(2, 64'd0, 64'd0);
    dir_check_hit_way_i = 8'h20;
    send(OP_NLINE, 49'h1240, '0, fl);
    wait_idle(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hpdcache_cmo_range.md
HPDCACHE_CMO_RANGE -- requirements
Module: hpdcache_cmo_range

Interface
REQ-001 SHALL have parameter SETS, 128, number of cache sets (power of 2, >=2).
REQ-002 SHALL have parameter WAYS, 8, number of ways (1..32).
REQ-003 SHALL have parameter PA_W, 49, request physical address width.
REQ-004 SHALL have parameter OFFSET_W, 6, line offset width; SET_W=$clog2(SETS), TAG_W=PA_W-OFFSET_W-SET_W.
REQ-005 SHALL have parameter CNT_W, 16, range line-count width.
REQ-006 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset, asynchronous, active-low.
REQ-007 SHALL have ports: wbuf_empty_i, mshr_empty_i, rtab_empty_i, ctrl_empty_i in 1 each; pipeline-idle indications.
REQ-008 SHALL have ports: req_valid_i in 1; req_ready_o out 1; req_op_i in 5 one-hot {fence, inval_nline, inval_set, inval_all, inval_range}; req_addr_i in PA_W; req_arg_i in 32 (way mask for inval_set in bits WAYS-1:0; line count for inval_range in bits CNT_W-1:0).
REQ-009 SHALL have ports: wbuf_flush_all_o out 1; done_o out 1, one-cycle completion pulse.
REQ-010 SHALL have ports: dir_check_o out 1; dir_check_set_o out SET_W; dir_check_tag_o out TAG_W; dir_check_hit_way_i in WAYS, valid the cycle after dir_check_o.
REQ-011 SHALL have ports: dir_inval_o out 1; dir_inval_set_o out SET_W; dir_inval_way_o out WAYS; dir_busy_i in 1.

Function
REQ-012 SHALL implement states IDLE, FENCE_WAIT, DRAIN_WAIT, CHECK, INVAL; req_ready_o=1 only in IDLE.
REQ-013 Fence accepted in IDLE: wbuf_flush_all_o=rtab_empty_i; if wbuf_empty_i&rtab_empty_i, done_o same cycle and stay IDLE, else go FENCE_WAIT.
REQ-014 FENCE_WAIT: wbuf_flush_all_o=rtab_empty_i each cycle; when wbuf_empty_i&rtab_empty_i, done_o=1 and go IDLE.
REQ-015 Inval ops accepted in IDLE: capture op, addr, way mask, count; clear set counter; go CHECK (nline/range) or INVAL (set/all) if mshr, rtab, ctrl all empty, else DRAIN_WAIT.
REQ-016 DRAIN_WAIT: hold until all three empty, then branch as REQ-015.
REQ-017 CHECK: if dir_busy_i, stall with no outputs; else dir_check_o=1 with set/tag from current line address, go INVAL.
REQ-018 INVAL nline: dir_inval_o=|hit, way=hit, set=current set; done_o=1; go IDLE.
REQ-019 INVAL range: as REQ-018 for current line; increment line address by one line (carry from set into tag) and decrement remaining count; if remaining was 1 then done_o and IDLE, else back to CHECK.
REQ-020 Range count 0 SHALL be treated as 1 line.
REQ-021 Range address increment SHALL wrap modulo 2^(PA_W-OFFSET_W) silently.
REQ-022 INVAL set: dir_inval_o=1, way=captured mask, set=addressed set; done_o; IDLE.
REQ-023 INVAL all: dir_inval_o=1, way=all ones, set=counter, counter+1 per cycle; at counter==SETS-1 done_o and IDLE; dir_busy_i stalls set/all (no inval, counter held).
REQ-024 dir_check_o and dir_inval_o SHALL never be asserted in the same cycle.
REQ-025 req_valid_i outside IDLE or non-one-hot op SHALL be ignored (simulation assertion fires).

Reset
REQ-026 State SHALL reset asynchronously to IDLE; all outputs 0 except req_ready_o=1.
REQ-027 Reset mid-operation SHALL abort without done_o; datapath registers need no reset.

Structure
REQ-028 CMO op type (5-bit one-hot struct) and state enum SHALL live in hpdcache_pkg.
REQ-029 No sub-module; single FSM with address/count/set-counter registers.

Verification
REQ-030 Fence with wbuf_empty_i=0 for 5 cycles -> wbuf_flush_all_o high 5 cycles, done_o on 6th, req_ready_o low meanwhile.
REQ-031 inval_range addr=0x1FC0, count=3, SETS=128 -> checks on set 127 tag 0, set 0 tag 1, set 1 tag 1; done_o after third INVAL.
REQ-032 inval_all with dir_busy_i high 2 cycles mid-sweep -> 128 dir_inval_o pulses, sets 0..127 each once, done_o on last.
REQ-033 inval_nline with mshr_empty_i=0 for 4 cycles then miss (hit=0) -> DRAIN_WAIT 4 cycles, dir_inval_o=0, done_o=1.
REQ-034 inval_set way mask 0x05 set 9 -> single dir_inval_o, way 0x05, set 9, done_o same cycle.
REQ-035 rst_ni low during range count=10 after 2 lines -> IDLE, no done_o, req_ready_o=1.
